// File: rtl/vn_debias_fifo.sv
// Von Neumann debiaser feeding a small bit FIFO with a valid/ready output.
// Raw bits are paired without overlap: 01 -> 0, 10 -> 1, 00/11 are discarded.
// Surviving bits are queued for the downstream monobit core. Saturating
// keep/discard counters and a sticky overflow flag are exported for status.
module vn_debias_fifo #(
   parameter int DEPTH = 8,
   parameter int CNT_W = 16
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       ena,
   input  logic                       clear,
   input  logic                       raw_bit,
   input  logic                       raw_valid,
   output logic                       out_bit,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [$clog2(DEPTH):0]     fill,
   output logic [CNT_W-1:0]           kept_cnt,
   output logic [CNT_W-1:0]           discard_cnt,
   output logic                       overflow
);

   localparam int PTR_W  = $clog2(DEPTH);
   localparam int FILL_W = PTR_W + 1;

   localparam logic [0:0] ST_EMPTY = 1'b0;
   localparam logic [0:0] ST_HALF  = 1'b1;

   logic [0:0]        state_q, state_d;
   logic              first_q, first_d;
   logic              mem_q [DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
   logic [FILL_W-1:0] fill_q;
   logic [CNT_W-1:0]  kept_q, disc_q;
   logic              ovf_q;
   logic              last_q;

   logic advance, pair_done, pair_keep, pair_drop;
   logic fifo_empty, fifo_full, pop_en, push_en, drop_bit;

   // Decode which pair event and which FIFO operations happen this cycle.
   always_comb begin
      advance    = ena & raw_valid & ~clear;
      pair_done  = advance & (state_q == ST_HALF);
      pair_keep  = pair_done & (raw_bit != first_q);
      pair_drop  = pair_done & (raw_bit == first_q);
      fifo_empty = (fill_q == '0);
      fifo_full  = (fill_q == FILL_W'(DEPTH));
      pop_en     = ~fifo_empty & out_ready & ~clear;
      push_en    = pair_keep & (~fifo_full | pop_en);
      drop_bit   = pair_keep & fifo_full & ~pop_en;
   end

   // Pair state machine: remember the first bit, resolve on the second.
   always_comb begin
      state_d = state_q;
      first_d = first_q;
      if (advance) begin
         case (state_q)
            ST_EMPTY: begin
               first_d = raw_bit;
               state_d = ST_HALF;
            end
            default: begin
               state_d = ST_EMPTY;
            end
         endcase
      end
   end

   // Pair state registers; a clear abandons any half-collected pair.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_EMPTY;
         first_q <= 1'b0;
      end else if (clear) begin
         state_q <= ST_EMPTY;
         first_q <= 1'b0;
      end else begin
         state_q <= state_d;
         first_q <= first_d;
      end
   end

   // FIFO storage; the kept bit of a differing pair is always the first bit.
   always_ff @(posedge clk) begin
      if (push_en) begin
         mem_q[wr_ptr_q] <= first_q;
      end
   end

   // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         fill_q   <= '0;
      end else if (clear) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         fill_q   <= '0;
      end else begin
         if (push_en) begin
            wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         end
         if (pop_en) begin
            rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         end
         case ({push_en, pop_en})
            2'b10:   fill_q <= fill_q + FILL_W'(1);
            2'b01:   fill_q <= fill_q - FILL_W'(1);
            default: fill_q <= fill_q;
         endcase
      end
   end

   // Holds the most recently popped bit so out_bit is stable while empty.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_q <= 1'b0;
      end else if (pop_en) begin
         last_q <= mem_q[rd_ptr_q];
      end
   end

   // Saturating keep/discard counters and the sticky overflow flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         kept_q <= '0;
         disc_q <= '0;
         ovf_q  <= 1'b0;
      end else if (clear) begin
         kept_q <= '0;
         disc_q <= '0;
         ovf_q  <= 1'b0;
      end else begin
         if (push_en && !(&kept_q)) begin
            kept_q <= kept_q + CNT_W'(1);
         end
         if (pair_drop && !(&disc_q)) begin
            disc_q <= disc_q + CNT_W'(1);
         end
         if (drop_bit) begin
            ovf_q <= 1'b1;
         end
      end
   end

   assign out_bit     = fifo_empty ? last_q : mem_q[rd_ptr_q];
   assign out_valid   = ~fifo_empty;
   assign fill        = fill_q;
   assign kept_cnt    = kept_q;
   assign discard_cnt = disc_q;
   assign overflow    = ovf_q;

endmodule

// File: tb/tb_vn_debias_fifo.sv
// Directed testbench for vn_debias_fifo (DEPTH=8, CNT_W=4 so saturation is reachable).
module tb_vn_debias_fifo;

   localparam int DEPTH = 8;
   localparam int CNT_W = 4;

   logic                   clk;
   logic                   rst_n;
   logic                   ena;
   logic                   clear;
   logic                   raw_bit;
   logic                   raw_valid;
   logic                   out_bit;
   logic                   out_valid;
   logic                   out_ready;
   logic [$clog2(DEPTH):0] fill;
   logic [CNT_W-1:0]       kept_cnt;
   logic [CNT_W-1:0]       discard_cnt;
   logic                   overflow;

   int errCount;
   int checkCount;

   vn_debias_fifo #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .ena         (ena),
      .clear       (clear),
      .raw_bit     (raw_bit),
      .raw_valid   (raw_valid),
      .out_bit     (out_bit),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .fill        (fill),
      .kept_cnt    (kept_cnt),
      .discard_cnt (discard_cnt),
      .overflow    (overflow)
   );

   // 10 ns clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Safety net so the run always ends
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   // Single comparison point: counts and reports mismatches
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errCount++;
         $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
      end
   endtask

   // Present one raw bit for one cycle, return #1 after the capturing edge
   task automatic applyStimulus(input logic b);
      @(negedge clk);
      raw_valid = 1'b1;
      raw_bit   = b;
      @(posedge clk);
      #1;
      raw_valid = 1'b0;
   endtask

   // One-cycle synchronous clear, optionally with raw_valid asserted
   task automatic clearPulse(input logic withRaw);
      @(negedge clk);
      clear     = 1'b1;
      raw_valid = withRaw;
      raw_bit   = 1'b1;
      @(posedge clk);
      #1;
      clear     = 1'b0;
      raw_valid = 1'b0;
   endtask

   logic pa [5];
   logic pb [5];
   logic ev [5];
   logic eb [5];

   initial begin
      errCount   = 0;
      checkCount = 0;
      ena        = 1'b1;
      clear      = 1'b0;
      raw_bit    = 1'b0;
      raw_valid  = 1'b0;
      out_ready  = 1'b1;
      rst_n      = 1'b1;
      #3;
      rst_n = 1'b0;
      #2;
      checkOutput("rst_valid", 32'(out_valid), 0);
      checkOutput("rst_fill", 32'(fill), 0);
      checkOutput("rst_bit", 32'(out_bit), 0);
      checkOutput("rst_kept", 32'(kept_cnt), 0);
      checkOutput("rst_disc", 32'(discard_cnt), 0);
      checkOutput("rst_ovf", 32'(overflow), 0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // Test 1: pairs 01,10,00,11,10 -> 0,1,1
      $display("[TB] basic pairing");
      pa = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
      pb = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
      ev = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
      eb = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
      for (int i = 0; i < 5; i++) begin
         applyStimulus(pa[i]);
         checkOutput($sformatf("p%0d_first_valid", i), 32'(out_valid), 0);
         applyStimulus(pb[i]);
         checkOutput($sformatf("p%0d_valid", i), 32'(out_valid), 32'(ev[i]));
         if (ev[i]) begin
            checkOutput($sformatf("p%0d_bit", i), 32'(out_bit), 32'(eb[i]));
         end
      end
      @(posedge clk);
      #1;
      checkOutput("t1_drained", 32'(out_valid), 0);
      checkOutput("t1_kept", 32'(kept_cnt), 3);
      checkOutput("t1_disc", 32'(discard_cnt), 2);
      checkOutput("t1_ovf", 32'(overflow), 0);

      // Test 2: fill to DEPTH with ready low, ninth bit overflows
      $display("[TB] overflow");
      clearPulse(1'b0);
      out_ready = 1'b0;
      for (int i = 0; i < 8; i++) begin
         applyStimulus(1'b1);
         applyStimulus(1'b0);
      end
      checkOutput("t2_fill8", 32'(fill), 8);
      checkOutput("t2_ovf_before", 32'(overflow), 0);
      applyStimulus(1'b1);
      applyStimulus(1'b0);
      checkOutput("t2_fill", 32'(fill), 8);
      checkOutput("t2_kept", 32'(kept_cnt), 8);
      checkOutput("t2_ovf", 32'(overflow), 1);
      @(negedge clk);
      out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         checkOutput($sformatf("t2_drain%0d_valid", i), 32'(out_valid), 1);
         checkOutput($sformatf("t2_drain%0d_bit", i), 32'(out_bit), 1);
         @(posedge clk);
         #1;
      end
      checkOutput("t2_empty", 32'(out_valid), 0);
      checkOutput("t2_ovf_sticky", 32'(overflow), 1);

      // Test 3: push into a full FIFO while it pops
      $display("[TB] full push with pop");
      out_ready = 1'b0;
      clearPulse(1'b0);
      checkOutput("t3_clr_ovf", 32'(overflow), 0);
      for (int i = 0; i < 8; i++) begin
         applyStimulus(1'b1);
         applyStimulus(1'b0);
      end
      applyStimulus(1'b0);
      @(negedge clk);
      raw_valid = 1'b1;
      raw_bit   = 1'b1;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      raw_valid = 1'b0;
      checkOutput("t3_fill", 32'(fill), 8);
      checkOutput("t3_ovf", 32'(overflow), 0);
      checkOutput("t3_kept", 32'(kept_cnt), 9);
      for (int i = 0; i < 8; i++) begin
         checkOutput($sformatf("t3_drain%0d_valid", i), 32'(out_valid), 1);
         checkOutput($sformatf("t3_drain%0d_bit", i), 32'(out_bit), (i == 7) ? 0 : 1);
         @(posedge clk);
         #1;
      end
      checkOutput("t3_empty", 32'(out_valid), 0);

      // Test 4: ena low freezes the half pair
      $display("[TB] enable gating");
      clearPulse(1'b0);
      applyStimulus(1'b1);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         ena       = 1'b0;
         raw_valid = 1'(i % 2);
         raw_bit   = 1'((i / 2) % 2);
         @(posedge clk);
         #1;
         checkOutput($sformatf("t4_off%0d_valid", i), 32'(out_valid), 0);
      end
      @(negedge clk);
      raw_valid = 1'b0;
      ena       = 1'b1;
      applyStimulus(1'b0);
      checkOutput("t4_valid", 32'(out_valid), 1);
      checkOutput("t4_bit", 32'(out_bit), 1);
      @(posedge clk);
      #1;
      checkOutput("t4_single", 32'(out_valid), 0);
      checkOutput("t4_kept", 32'(kept_cnt), 1);
      checkOutput("t4_disc", 32'(discard_cnt), 0);

      // Test 5: discard saturation, then clear ignoring raw input
      $display("[TB] saturation and clear");
      clearPulse(1'b0);
      for (int i = 0; i < 20; i++) begin
         applyStimulus(1'b1);
         applyStimulus(1'b1);
      end
      checkOutput("t5_disc_sat", 32'(discard_cnt), 15);
      checkOutput("t5_kept0", 32'(kept_cnt), 0);
      out_ready = 1'b0;
      applyStimulus(1'b1);
      applyStimulus(1'b0);
      applyStimulus(1'b1);
      applyStimulus(1'b0);
      checkOutput("t5_fill2", 32'(fill), 2);
      out_ready = 1'b1;
      clearPulse(1'b1);
      checkOutput("t5_clr_disc", 32'(discard_cnt), 0);
      checkOutput("t5_clr_kept", 32'(kept_cnt), 0);
      checkOutput("t5_clr_fill", 32'(fill), 0);
      checkOutput("t5_clr_valid", 32'(out_valid), 0);
      applyStimulus(1'b0);
      applyStimulus(1'b1);
      checkOutput("t5_new_valid", 32'(out_valid), 1);
      checkOutput("t5_new_bit", 32'(out_bit), 0);

      // Test 6: async reset mid-pair with fill=3
      $display("[TB] async reset");
      clearPulse(1'b0);
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b1);
         applyStimulus(1'b0);
      end
      checkOutput("t6_fill3", 32'(fill), 3);
      applyStimulus(1'b1);
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("t6_rst_valid", 32'(out_valid), 0);
      checkOutput("t6_rst_fill", 32'(fill), 0);
      checkOutput("t6_rst_kept", 32'(kept_cnt), 0);
      @(negedge clk);
      rst_n = 1'b1;
      applyStimulus(1'b0);
      checkOutput("t6_half_valid", 32'(out_valid), 0);
      applyStimulus(1'b1);
      checkOutput("t6_pair_valid", 32'(out_valid), 1);
      checkOutput("t6_pair_bit", 32'(out_bit), 0);
      checkOutput("t6_pair_fill", 32'(fill), 1);

      $display("Result: errors=%0d of %0d checks", errCount, checkCount);
      $finish;
   end

endmodule
